// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Measures the period of a slow, asynchronous clock (sig_in) in clk_in cycles.
// sig_in is synchronised, and each rising edge produces a one-cycle tick. The
// number of clk_in cycles between consecutive edges is reported on period_out,
// qualified by a one-cycle period_valid pulse. locked asserts after LOCK_COUNT
// consecutive periods fall within EXPECTED +/- TOL. timeout_out asserts when
// no edge arrives within TIMEOUT cycles.
//
// Ports:
//   clk_in        in   system clock
//   reset_in      in   asynchronous, active-high reset
//   sig_in        in   slow clock to measure (asynchronous to clk_in)
//   tick_out      out  one-cycle pulse per detected rising edge of sig_in
//   period_out    out  [CNT_W] last measured period in clk_in cycles
//   period_valid  out  one-cycle pulse when period_out updates
//   locked        out  LOCK_COUNT consecutive in-tolerance periods seen
//   timeout_out   out  no edge within TIMEOUT cycles
//
// Optional feature, enabled by defining CLOCK_PERIOD_METER_HIST_EN:
//   clear_hist    in   resets the min/max history on the next posedge
//   period_min    out  [CNT_W] smallest period since reset / clear
//   period_max    out  [CNT_W] largest period since reset / clear
// -----------------------------------------------------------------------------
module clock_period_meter #(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned EXPECTED   = 100000,
    parameter int unsigned TOL        = 16,
    parameter int unsigned TIMEOUT    = 200000,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             sig_in,
    output logic             tick_out,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout_out
`ifdef CLOCK_PERIOD_METER_HIST_EN
    ,
    input  logic             clear_hist,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    // Tolerance window as CNT_W-bit unsigned bounds; the lower bound clamps
    // at zero instead of wrapping when EXPECTED < TOL.
    localparam logic [CNT_W-1:0] TOL_LO    = (EXPECTED > TOL) ? CNT_W'(EXPECTED - TOL) : '0;
    localparam logic [CNT_W-1:0] TOL_HI    = CNT_W'(EXPECTED + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam int unsigned        MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_C  = MATCH_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL
    } state_t;

    state_t             state_q;
    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MATCH_W-1:0] match_q;
    logic               tick_q;
    logic [CNT_W-1:0]   period_q;
    logic               valid_q;
    logic               locked_q;
    logic               timeout_q;

    logic               sig_edge;
    logic               report_d;
    logic               in_tol;
    logic [MATCH_W-1:0] match_d;

    assign sig_edge = sync2_q & ~prev_q;

    // A period is only reported when an edge closes an interval that was
    // fully measured, i.e. while running. IDLE and STALL edges just restart.
    assign report_d = (state_q == ST_RUN) && sig_edge;

    assign in_tol = (cnt_q >= TOL_LO) && (cnt_q <= TOL_HI);

    // NOTE: next-state terms are continuous assigns with a value on every
    // path, so no storage can be inferred outside the clocked block.
    assign match_d = !in_tol              ? '0      :
                     (match_q == LOCK_C)  ? match_q :
                                            match_q + 1'b1;

    // Synchroniser, period counter, lock tracking and registered outputs.
    // tick_out, period_valid and locked all update on the same posedge.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            match_q   <= '0;
            tick_q    <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the three flops shift as a
            // chain; each stage sees its predecessor's value from before the edge.
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= sig_edge;
            valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (sig_edge) begin
                        state_q <= ST_RUN;
                        cnt_q   <= CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    // An edge on the timeout cycle still closes a valid period.
                    if (sig_edge) begin
                        period_q <= cnt_q;
                        valid_q  <= 1'b1;
                        cnt_q    <= CNT_W'(1);
                        match_q  <= match_d;
                        locked_q <= (match_d == LOCK_C);
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q   <= ST_STALL;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        match_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_STALL: begin
                    if (sig_edge) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= CNT_W'(1);
                        timeout_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tick_out     = tick_q;
    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout_out  = timeout_q;

`ifdef CLOCK_PERIOD_METER_HIST_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // Starting from min = all-ones and max = 0 makes the first reported
    // period load both without a separate "empty" flag. Clear beats a
    // coinciding period, which is then simply dropped from the history.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            min_q <= '1;
            max_q <= '0;
        end else if (clear_hist) begin
            min_q <= '1;
            max_q <= '0;
        end else if (report_d) begin
            if (cnt_q < min_q) min_q <= cnt_q;
            if (cnt_q > max_q) max_q <= cnt_q;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

    localparam int CNT_W      = 27;
    localparam int EXPECTED   = 100;
    localparam int TOL        = 2;
    localparam int TIMEOUT    = 300;
    localparam int LOCK_COUNT = 4;
    localparam longint ALL1   = (64'd1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic             sig_in;
    logic             tick_out;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             timeout_out;
`ifdef CLOCK_PERIOD_METER_HIST_EN
    logic             clear_hist;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
`endif

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .EXPECTED   (EXPECTED),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .sig_in       (sig_in),
        .tick_out     (tick_out),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout_out  (timeout_out)
`ifdef CLOCK_PERIOD_METER_HIST_EN
        ,
        .clear_hist   (clear_hist),
        .period_min   (period_min),
        .period_max   (period_max)
`endif
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Works purely from the times at which the bench raised sig_in: the period
    // is the cycle distance between rises, a distance over TIMEOUT is a stall.
    typedef struct {
        longint period;
        bit     lck;
        longint mn;
        longint mx;
    } exp_t;

    exp_t   q[$];
    bit     have_prev = 0;
    int     prev_cyc  = 0;
    int     match     = 0;
    int     exp_ticks = 0;
    int     act_ticks = 0;
    int     exp_to    = 0;
    int     act_to    = 0;
    longint m_min     = ALL1;
    longint m_max     = 0;

    function automatic void model_edge();
        int   gap;
        int   lo;
        exp_t e;
        exp_ticks++;
        if (have_prev) begin
            gap = cyc - prev_cyc;
            if (gap <= TIMEOUT) begin
                lo = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
                if (gap >= lo && gap <= EXPECTED + TOL)
                    match = (match < LOCK_COUNT) ? match + 1 : match;
                else
                    match = 0;
                if (gap < m_min) m_min = gap;
                if (gap > m_max) m_max = gap;
                e.period = gap;
                e.lck    = (match == LOCK_COUNT);
                e.mn     = m_min;
                e.mx     = m_max;
                q.push_back(e);
            end else begin
                exp_to++;
                match = 0;
            end
        end
        have_prev = 1;
        prev_cyc  = cyc;
    endfunction

    // Raise sig_in now (called at a negedge) and schedule the next rise
    // exactly gap cycles later.
    task automatic edge_then(input int gap);
        sig_in = 1'b1;
        model_edge();
        repeat (gap / 2) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (gap - gap / 2) @(negedge clk_in);
    endtask

    task automatic do_reset();
        #3;
        reset_in = 1'b1;
        sig_in   = 1'b0;
        #1;
        check("rst_tick",    tick_out, 0);
        check("rst_valid",   period_valid, 0);
        check("rst_period",  period_out, 0);
        check("rst_locked",  locked, 0);
        check("rst_timeout", timeout_out, 0);
        check("rst_queue_empty", q.size(), 0);
        q.delete();
        have_prev = 0;
        match     = 0;
        m_min     = ALL1;
        m_max     = 0;
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
    endtask

    // ---------------- monitor ----------------
    int last_tick = 0;
    bit to_prev   = 0;

    always @(posedge clk_in) begin
        exp_t e;
        #1;
        cyc++;
        if (tick_out) begin
            act_ticks++;
            last_tick = cyc;
            check("timeout_low_on_tick", timeout_out, 0);
        end
        if (period_valid) begin
            check("valid_aligned_tick", tick_out, 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got period %0d expected no report (cycle %0d)", period_out, cyc);
            end else begin
                e = q.pop_front();
                check("period", period_out, e.period);
                check("locked", locked, e.lck);
`ifdef CLOCK_PERIOD_METER_HIST_EN
                check("hist_min", period_min, e.mn);
                check("hist_max", period_max, e.mx);
`endif
            end
        end
        if (timeout_out && !to_prev) begin
            act_to++;
            check("timeout_delay", cyc - last_tick, TIMEOUT);
            check("timeout_locked", locked, 0);
        end
        to_prev = timeout_out;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1 ms");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_in = 1'b1;
        sig_in   = 1'b0;
`ifdef CLOCK_PERIOD_METER_HIST_EN
        clear_hist = 1'b0;
`endif
        repeat (3) @(negedge clk_in);
        check("init_tick",    tick_out, 0);
        check("init_valid",   period_valid, 0);
        check("init_period",  period_out, 0);
        check("init_locked",  locked, 0);
        check("init_timeout", timeout_out, 0);
`ifdef CLOCK_PERIOD_METER_HIST_EN
        check("init_min", period_min, ALL1);
        check("init_max", period_max, 0);
`endif
        reset_in = 1'b0;
        @(negedge clk_in);

        // Ideal 100-cycle square wave, 6 edges.
        repeat (6) edge_then(100);
        check("t1_locked", locked, 1);

        // 100,100,100,103,100: the 103 breaks the run.
        do_reset();
        edge_then(100); edge_then(100); edge_then(100);
        edge_then(103); edge_then(100); edge_then(20);
        check("t2_locked", locked, 0);

        // Lock, then stall, recover, then an edge exactly on the timeout cycle.
        do_reset();
        repeat (4) edge_then(100);
        edge_then(450);
        check("t3_timeout_set", timeout_out, 1);
        check("t3_locked_clr",  locked, 0);
        edge_then(100);
        check("t3_timeout_clr", timeout_out, 0);
        edge_then(300);
        edge_then(20);
        check("t4_no_timeout", timeout_out, 0);

        // Asynchronous reset mid-period.
        do_reset();
        edge_then(100);
        sig_in = 1'b1;
        model_edge();
        repeat (40) @(negedge clk_in);
        do_reset();
        edge_then(100);
        edge_then(20);

`ifdef CLOCK_PERIOD_METER_HIST_EN
        do_reset();
        edge_then(98); edge_then(101); edge_then(99);
        sig_in = 1'b1;
        model_edge();
        repeat (5) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (5) @(negedge clk_in);
        check("h_min", period_min, 98);
        check("h_max", period_max, 101);
        clear_hist = 1'b1;
        @(negedge clk_in);
        clear_hist = 1'b0;
        m_min = ALL1;
        m_max = 0;
        check("h_clr_min", period_min, ALL1);
        check("h_clr_max", period_max, 0);
        repeat (89) @(negedge clk_in);
        edge_then(20);
        check("h_new_min", period_min, 100);
        check("h_new_max", period_max, 100);
`endif

        // Randomised periods around nominal with occasional near/over-timeout gaps.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                edge_then(int'($urandom_range(290, 320)));
            else
                edge_then(int'($urandom_range(96, 104)));
        end
        edge_then(10);

        check("final_queue_empty", q.size(), 0);
        check("tick_count", act_ticks, exp_ticks);
        check("timeout_count", act_to, exp_to);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
